// File: rtl/pmod_in_if.sv
// Sample-pair handshake between the PmodI2S2 line-in receiver and its consumer.
// The receiver drives the pair and the sticky overrun flag; the consumer drives out_ready.
interface pmod_in_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;

  modport master (
    output out_left,
    output out_right,
    output out_valid,
    output overrun,
    input  out_ready
  );

  modport slave (
    input  out_left,
    input  out_right,
    input  out_valid,
    input  overrun,
    output out_ready
  );
endinterface

// File: rtl/pmod_in.sv
// PmodI2S2 line-in receiver: generates mclk/sclk/lrck from clk and
// deserialises I2S left/right words into a valid/ready sample pair.
module pmod_in #(
  parameter int DATA_W = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      sdin,
  output logic      mclk,
  output logic      sclk,
  output logic      lrck,
  pmod_in_if.master pair
);

  localparam logic [4:0] LSB_SLOT = 5'(DATA_W);
  localparam logic [3:0] CAP_PH   = 4'd12;

  logic [9:0]        cnt;
  logic              sdin_q;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] right_q;
  logic              valid_q;
  logic              ovr_q;

  logic [4:0]        slot;
  logic              cap;
  logic              in_word;
  logic              lsb_cap;
  logic              left_done;
  logic              pair_done;
  logic              xfer;
  logic [DATA_W-1:0] word_nxt;

  assign slot      = cnt[8:4];
  assign cap       = en && (cnt[3:0] == CAP_PH);
  assign in_word   = (slot != 5'd0) && (slot <= LSB_SLOT);
  assign lsb_cap   = cap && (slot == LSB_SLOT);
  assign left_done = lsb_cap && !cnt[9];
  assign pair_done = lsb_cap && cnt[9];
  assign xfer      = valid_q && pair.out_ready;
  assign word_nxt  = {shift[DATA_W-2:0], sdin_q};

  // Clocks come straight off counter flops, so they cannot glitch.
  assign mclk = cnt[1];
  assign sclk = cnt[3];
  assign lrck = cnt[9];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 10'd0;
    end else if (en) begin
      cnt <= cnt + 10'd1;
    end else begin
      cnt <= 10'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdin_q <= 1'b0;
    end else begin
      sdin_q <= sdin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      hold  <= '0;
    end else if (!en) begin
      shift <= '0;
      hold  <= '0;
    end else begin
      if (cap && in_word) begin
        shift <= word_nxt;
      end
      if (left_done) begin
        hold <= word_nxt;
      end
    end
  end

  // A completing pair wins over a transfer; it only overruns if unconsumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (pair_done) begin
      left_q  <= hold;
      right_q <= word_nxt;
      valid_q <= 1'b1;
      if (valid_q && !pair.out_ready) begin
        ovr_q <= 1'b1;
      end
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  assign pair.out_left  = left_q;
  assign pair.out_right = right_q;
  assign pair.out_valid = valid_q;
  assign pair.overrun   = ovr_q;

endmodule

// File: tb/tb_pmod_in.sv
// Directed bench for pmod_in: I2S ADC model, clock ratios, backpressure,
// coincident transfer, enable drop and asynchronous reset.
module tb_pmod_in;

  logic clk;
  logic rst;
  logic en;
  logic sdin;
  logic mclk;
  logic sclk;
  logic lrck;

  pmod_in_if #(.DATA_W(16)) pif ();

  pmod_in #(.DATA_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .sdin (sdin),
    .mclk (mclk),
    .sclk (sclk),
    .lrck (lrck),
    .pair (pif)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [9:0]  mcnt;
  logic [15:0] left_w;
  logic [15:0] right_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame counter
  always @(posedge clk or posedge rst) begin
    if (rst)      mcnt <= 10'd0;
    else if (!en) mcnt <= 10'd0;
    else          mcnt <= mcnt + 10'd1;
  end

  function automatic logic adc_bit(input logic [9:0] c);
    logic [15:0] w;
    int b;
    w = c[9] ? right_w : left_w;
    b = int'(c[8:4]);
    if (b >= 1 && b <= 16) return w[16-b];
    return 1'b0;
  endfunction

  // ADC changes data after sclk falls, one-bit delayed I2S framing
  always @(negedge clk) sdin = adc_bit(mcnt);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_to(input logic [9:0] target, output int vseen);
    int i;
    vseen = 0;
    i = 0;
    do begin
      @(negedge clk);
      i++;
      if (mcnt != target && pif.out_valid) vseen++;
    end while (mcnt != target && i < 2100);
    chk("reach", {22'd0, mcnt}, {22'd0, target});
  endtask

  initial begin
    int vs;
    int errs;
    int r_m, r_s, r_l, h_m, h_s, h_l, bad_edge;
    logic pm, ps, pl;

    rst = 1'b1;
    en = 1'b0;
    sdin = 1'b0;
    pif.out_ready = 1'b0;
    left_w = 16'hA5C3;
    right_w = 16'h1234;
    repeat (3) tick();

    chk("rst_valid", {31'd0, pif.out_valid}, 32'd0);
    chk("rst_ovr", {31'd0, pif.overrun}, 32'd0);
    chk("rst_left", {16'd0, pif.out_left}, 32'd0);
    chk("rst_right", {16'd0, pif.out_right}, 32'd0);
    chk("rst_clks", {29'd0, mclk, sclk, lrck}, 32'd0);

    // Basic pair
    rst = 1'b0;
    en = 1'b1;
    pif.out_ready = 1'b1;
    run_to(10'd780, vs);
    chk("basic_early", vs, 0);
    chk("basic_v780", {31'd0, pif.out_valid}, 32'd0);
    tick();
    chk("basic_v781", {31'd0, pif.out_valid}, 32'd1);
    chk("basic_left", {16'd0, pif.out_left}, 32'h0000A5C3);
    chk("basic_right", {16'd0, pif.out_right}, 32'h00001234);
    tick();
    chk("basic_v782", {31'd0, pif.out_valid}, 32'd0);

    // Clock ratios over 4096 clk
    errs = 0;
    r_m = 0; r_s = 0; r_l = 0;
    h_m = 0; h_s = 0; h_l = 0;
    bad_edge = 0;
    pm = mclk; ps = sclk; pl = lrck;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (mclk && !pm) r_m++;
      if (sclk && !ps) r_s++;
      if (lrck && !pl) r_l++;
      if (mclk) h_m++;
      if (sclk) h_s++;
      if (lrck) h_l++;
      if (lrck != pl && !(ps && !sclk)) bad_edge++;
      if (mclk != mcnt[1] || sclk != mcnt[3] || lrck != mcnt[9]) errs++;
      pm = mclk; ps = sclk; pl = lrck;
    end
    chk("clk_phase", errs, 0);
    chk("mclk_rises", r_m, 1024);
    chk("sclk_rises", r_s, 256);
    chk("lrck_rises", r_l, 4);
    chk("mclk_duty", h_m, 2048);
    chk("sclk_duty", h_s, 2048);
    chk("lrck_duty", h_l, 2048);
    chk("lrck_align", bad_edge, 0);
    chk("pre_bp_ovr", {31'd0, pif.overrun}, 32'd0);

    // Backpressure across two frames
    run_to(10'd800, vs);
    pif.out_ready = 1'b0;
    left_w = 16'h0001;
    right_w = 16'h0002;
    run_to(10'd781, vs);
    chk("bp0_early", vs, 0);
    chk("bp0_valid", {31'd0, pif.out_valid}, 32'd1);
    chk("bp0_left", {16'd0, pif.out_left}, 32'h00000001);
    chk("bp0_right", {16'd0, pif.out_right}, 32'h00000002);
    chk("bp0_ovr", {31'd0, pif.overrun}, 32'd0);
    run_to(10'd800, vs);
    left_w = 16'h7FFF;
    right_w = 16'h8000;
    run_to(10'd781, vs);
    chk("bp1_valid", {31'd0, pif.out_valid}, 32'd1);
    chk("bp1_left", {16'd0, pif.out_left}, 32'h00007FFF);
    chk("bp1_right", {16'd0, pif.out_right}, 32'h00008000);
    chk("bp1_ovr", {31'd0, pif.overrun}, 32'd1);
    pif.out_ready = 1'b1;
    tick();
    chk("bp_drain", {31'd0, pif.out_valid}, 32'd0);
    chk("bp_sticky", {31'd0, pif.overrun}, 32'd1);

    // Async reset mid right word
    run_to(10'd700, vs);
    left_w = 16'h0F0F;
    right_w = 16'hF0F0;
    #1 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, pif.out_valid}, 32'd0);
    chk("ar_ovr", {31'd0, pif.overrun}, 32'd0);
    chk("ar_data", {pif.out_left, pif.out_right}, 32'd0);
    chk("ar_clks", {29'd0, mclk, sclk, lrck}, 32'd0);
    #2 rst = 1'b0;
    run_to(10'd780, vs);
    chk("ar_early", vs, 0);
    chk("ar_v780", {31'd0, pif.out_valid}, 32'd0);
    tick();
    chk("ar_v781", {31'd0, pif.out_valid}, 32'd1);
    chk("ar_pair", {pif.out_left, pif.out_right}, 32'h0F0FF0F0);

    // Coincident transfer and pair completion
    pif.out_ready = 1'b0;
    run_to(10'd800, vs);
    left_w = 16'h1357;
    right_w = 16'h2468;
    run_to(10'd780, vs);
    chk("co_pend", {31'd0, pif.out_valid}, 32'd1);
    pif.out_ready = 1'b1;
    tick();
    pif.out_ready = 1'b0;
    chk("co_valid", {31'd0, pif.out_valid}, 32'd1);
    chk("co_pair", {pif.out_left, pif.out_right}, 32'h13572468);
    chk("co_ovr", {31'd0, pif.overrun}, 32'd0);
    tick();
    chk("co_hold", {31'd0, pif.out_valid}, 32'd1);
    pif.out_ready = 1'b1;
    tick();
    chk("co_drain", {31'd0, pif.out_valid}, 32'd0);

    // Enable drop at cnt=300 for 10 clk
    run_to(10'd300, vs);
    en = 1'b0;
    left_w = 16'h5A5A;
    right_w = 16'hC3C3;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mclk || sclk || lrck) errs++;
      if (pif.out_left != 16'h1357 || pif.out_right != 16'h2468) errs++;
    end
    chk("en_off", errs, 0);
    en = 1'b1;
    run_to(10'd780, vs);
    chk("en_early", vs, 0);
    chk("en_v780", {31'd0, pif.out_valid}, 32'd0);
    tick();
    chk("en_v781", {31'd0, pif.out_valid}, 32'd1);
    chk("en_pair", {pif.out_left, pif.out_right}, 32'h5A5AC3C3);
    chk("en_ovr", {31'd0, pif.overrun}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
